// File: rtl/wb_pkg.sv
// Shared MEM/WB word layout, vector geometry and writeback state encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package wb_pkg;
    localparam int LANES      = 9;
    localparam int LANE_W     = 16;
    localparam int BEAT_LANES = 3;
    localparam int RC_W       = 4;

    // Field offsets inside the MEM/WB word; the memory stage packs with the same values.
    localparam int VEC_LSB       = 38;
    localparam int MEMQ_LSB      = 22;
    localparam int RC_LSB        = 18;
    localparam int MEMTOREG_BIT  = 17;
    localparam int REGWRITE_BIT  = 16;
    localparam int REGWRITEV_BIT = 15;
    localparam int MODESEL_BIT   = 14;

    typedef enum logic {IDLE, VEC} wb_state_t;
endpackage

// File: rtl/vec_beat_serializer.sv
// Holds a captured vector result and slices it into register-file beats.
// Latency: beat k appears k+1 cycles after load; one beat per cycle while active.
// Backpressure: none internally; last_beat tells the owner when a new load can land.
module vec_beat_serializer #(
    parameter int N_BEATS = 3,
    parameter int B_W     = 48,
    parameter int A_W     = 4,
    parameter int I_W     = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load,
    input  logic                     active,
    input  logic [A_W-1:0]           load_rc,
    input  logic [N_BEATS*B_W-1:0]   load_vec,
    output logic                     vregWe,
    output logic [A_W-1:0]           vregAddr,
    output logic [I_W-1:0]           vregBeat,
    output logic [B_W-1:0]           vregData,
    output logic                     last_beat
);
    localparam logic [I_W-1:0] LAST = I_W'(N_BEATS - 1);

    logic [N_BEATS*B_W-1:0] vec_q;
    logic [A_W-1:0]         rc_q;
    logic [I_W-1:0]         beat_q;

    // A load on the final beat restarts at beat 0 so vectors can run back to back.
    always_ff @(posedge clk) begin
        if (!rst) begin
            vec_q  <= '0;
            rc_q   <= '0;
            beat_q <= '0;
        end else if (load) begin
            vec_q  <= load_vec;
            rc_q   <= load_rc;
            beat_q <= '0;
        end else if (active) begin
            beat_q <= last_beat ? '0 : beat_q + 1'b1;
        end
    end

    assign last_beat = active && (beat_q == LAST);
    assign vregWe    = active;
    assign vregAddr  = rc_q;
    assign vregBeat  = beat_q;
    assign vregData  = vec_q[beat_q*B_W +: B_W];
endmodule

// File: rtl/writeback_stage.sv
// Retires MEM/WB words: scalar write one cycle after accept, vector write serialised over BEATS cycles.
// Latency: 1 cycle to sreg/first vreg beat; vector occupies BEATS cycles.
// Backpressure: in_ready low while a vector has beats left beyond the current one.
module writeback_stage
    import wb_pkg::*;
#(
    parameter int LANES      = wb_pkg::LANES,
    parameter int LANE_W     = wb_pkg::LANE_W,
    parameter int BEAT_LANES = wb_pkg::BEAT_LANES,
    parameter int RC_W       = wb_pkg::RC_W,
    localparam int BEATS     = LANES / BEAT_LANES,
    localparam int BEAT_W    = BEAT_LANES * LANE_W,
    localparam int BUF_W     = LANES * LANE_W + 38,
    localparam int BIDX_W    = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [BUF_W-1:0]  bufferIn,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              sregWe,
    output logic [RC_W-1:0]   sregAddr,
    output logic [LANE_W-1:0] sregData,
    output logic              vregWe,
    output logic [RC_W-1:0]   vregAddr,
    output logic [BIDX_W-1:0] vregBeat,
    output logic [BEAT_W-1:0] vregData,
    output logic              busy
);
    logic [LANES*LANE_W-1:0] vec_in;
    logic [LANE_W-1:0]       mem_q;
    logic [RC_W-1:0]         rc_in;
    logic                    mem_to_reg, reg_write, reg_write_v;
    logic                    unused_bits;

    assign vec_in      = bufferIn[VEC_LSB +: LANES*LANE_W];
    assign mem_q       = bufferIn[MEMQ_LSB +: LANE_W];
    assign rc_in       = bufferIn[RC_LSB +: RC_W];
    assign mem_to_reg  = bufferIn[MEMTOREG_BIT];
    assign reg_write   = bufferIn[REGWRITE_BIT];
    assign reg_write_v = bufferIn[REGWRITEV_BIT];
    assign unused_bits = ^bufferIn[MODESEL_BIT:0];

    wb_state_t state_q, state_d;
    logic      last_beat, accept, load_vec;

    assign in_ready = (state_q == IDLE) || last_beat;
    assign accept   = en && in_valid && in_ready;
    assign load_vec = accept && reg_write_v;
    assign busy     = (state_q == VEC);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (load_vec) state_d = VEC;
            VEC:  if (last_beat && !load_vec) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Register 0 is hardwired zero on the scalar file only.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sregWe   <= 1'b0;
            sregAddr <= '0;
            sregData <= '0;
        end else begin
            sregWe <= accept && reg_write && (rc_in != '0);
            if (accept && reg_write) begin
                sregAddr <= rc_in;
                sregData <= mem_to_reg ? mem_q : vec_in[LANE_W-1:0];
            end
        end
    end

    vec_beat_serializer #(
        .N_BEATS (BEATS),
        .B_W     (BEAT_W),
        .A_W     (RC_W),
        .I_W     (BIDX_W)
    ) u_ser (
        .clk       (clk),
        .rst       (rst),
        .load      (load_vec),
        .active    (busy),
        .load_rc   (rc_in),
        .load_vec  (vec_in),
        .vregWe    (vregWe),
        .vregAddr  (vregAddr),
        .vregBeat  (vregBeat),
        .vregData  (vregData),
        .last_beat (last_beat)
    );
endmodule
